xram2_arb: RTL
==============

# xram2_arb

Round-robin arbiter and read-response router that shares port B of the single-clock true-dual-port block RAM among `NUM_REQ` requesters, such as the RISC-V data port, a program loader and a debug access unit. Each cycle it accepts at most one request, drives the RAM port-B controls, and tracks each read through the RAM's fixed read latency so the data returns to the requester that issued it. Port A stays dedicated to instruction fetch and is not handled here.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2 to 8.
- `ADDR_W`, default 10: RAM address width.
- `DATA_W`, default 32: RAM data width.
- `RD_LAT`, default 1: RAM read latency in cycles. 1 means the LOW_LATENCY RAM build; 2 means HIGH_PERFORMANCE.

Ports:
- `clka`  in  1  clock; the same clock as the RAM.
- `rstn`  in  1  reset; asynchronous assert, active-low.
- `req_valid`  in  NUM_REQ  request valid, one bit per requester.
- `req_ready`  out  NUM_REQ  one-hot grant.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_W  flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  NUM_REQ*DATA_W  flattened write data.
- `rsp_valid`  out  NUM_REQ  read data valid, one-hot.
- `rsp_rdata`  out  DATA_W  read data, shared by all requesters.
- `ram_en`, `ram_we`  out  1  port-B enable and write enable.
- `ram_addr`  out  ADDR_W  port-B address.
- `ram_din`  out  DATA_W  port-B write data.
- `ram_regce`  out  1  port-B output register enable.
- `ram_rst`  out  1  port-B output reset; tied to 0.
- `ram_dout`  in  DATA_W  port-B read data.

## Operation
- Grant is computed combinationally each cycle.
  - The search order starts at `last+1`, wraps modulo `NUM_REQ`, and picks the first requester with valid high.
  - `req_ready` is high only for the winner, and only when at least one valid is high.
- Accept = `req_valid[i] & req_ready[i]`. On accept:
  - `ram_en` = 1.
  - `ram_we`, `ram_addr` and `ram_din` carry the winner's fields, combinationally in the same cycle.
  - `last` is updated to the winner.
- With no accept, `ram_en` = 0 and `ram_we` = 0.
- Requester rules: once valid is raised it must stay high with stable fields until ready is seen. The arbiter does not check this.
- Reads: an accepted read pushes a tag (valid, id) into a shift pipe `RD_LAT` stages deep.
  - When the tag leaves the pipe, `rsp_valid[id]` = 1 for one cycle.
  - In that cycle `rsp_rdata` = `ram_dout`.
- Writes produce no response. They are complete when accepted.
- `ram_regce` = tag-stage-1 valid when `RD_LAT` = 2, and 1 when `RD_LAT` = 1.
- `rsp_rdata` = `ram_dout` at all times; its value is meaningful only while some `rsp_valid` is high.
- Throughput: one request per cycle, with no bubbles between grants.
- Read-after-write to the same address in consecutive cycles returns the new data.

## Timing
- Reset values:
  - `last` = `NUM_REQ-1`, so requester 0 wins first.
  - Tag pipe cleared; `rsp_valid` = 0.
  - `ram_en`, `ram_we`, `ram_regce` and `ram_rst` = 0.
  - `ram_addr` and `ram_din` = 0, because no requester is granted.
- Read latency is exactly `RD_LAT` cycles from the accept edge to `rsp_valid`.
- Reset asserted mid-operation: in-flight read responses are dropped with no `rsp_valid` pulse, and the pointer returns to its reset value.
- Only one requester valid: it is granted every cycle, back to back.
- All requesters valid: service order is 0, 1, …, NUM_REQ-1, 0, …
- The `rsp_valid` of one read and the acceptance of a new request may occur in the same cycle.

## Configuration
- `XRAM2_ARB_FIXED_PRIO_EN` defined:
  - Requester 0 wins whenever its valid is high.
  - Requesters 1..NUM_REQ-1 round-robin among themselves. `last` tracks only their grants and resets to `NUM_REQ-1`.
- Not defined: pure round-robin over all requesters, as described under Operation.

## Structure
- Package `xram2_arb_pkg`:
  - `clog2` function.
  - `ID_W = clog2(NUM_REQ)` as the id width.
  - Tag struct {valid, id}.
  - Reset constants.
- Sub-module `rr_pick`: purely combinational rotate-priority picker.
  - Inputs: request vector and `last`.
  - Outputs: one-hot grant and encoded winner.
  - It is instantiated once; the fixed-priority override wraps around it.

## Test plan
- Reset, then requester 2 reads address 0x005 that was preloaded with 0xDEADBEEF:
  - `ram_en` = 1 and `ram_addr` = 0x005 in the accept cycle.
  - `rsp_valid` = 0b0100 and `rsp_rdata` = 0xDEADBEEF exactly `RD_LAT` cycles later.
- All 4 requesters hold valid reads for 8 cycles after reset: grants are 0, 1, 2, 3, 0, 1, 2, 3, and each `rsp_valid` bit arrives in the same order.
- Requester 1 writes 0x12345678 to 0x3FF; in the next cycle requester 3 reads 0x3FF: 0x12345678 is returned on `rsp_valid[3]`.
- `rstn` is pulsed low while 2 reads are in flight:
  - No `rsp_valid` pulse occurs.
  - The first grant after release goes to requester 0.
- Repeat the run with `RD_LAT` = 2 and the HIGH_PERFORMANCE RAM: `ram_regce` is high exactly 1 cycle after each read accept, and the data is correct.
- With `XRAM2_ARB_FIXED_PRIO_EN` defined, requesters 0 and 2 stay valid for 3 cycles: requester 0 is granted all 3 cycles. Requester 0 then drops and requester 2 is granted.

Source files
------------

// File: rtl/xram2_arb_pkg.sv
// Shared types and constants for the port-B arbiter of the dual-port xram.
package xram2_arb_pkg;

  // Largest supported requester count; sizes the id field of the read tag.
  localparam int MAX_REQ = 8;

  // Ceiling log2 with a floor of 1 so a 1-bit id is always available.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) begin
        width = i + 1;
      end
    end
    return width;
  endfunction

  localparam int TAG_ID_W = clog2(MAX_REQ);

  // One slot of the read-latency shift pipe.
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } rd_tag_t;

  localparam rd_tag_t TAG_RESET     = '0;
  localparam logic    RAM_RST_VALUE = 1'b0;

endpackage

// File: rtl/xram2_arb_pick.sv
// Combinational rotate-priority picker: first set request after 'last', wrapping.
module rr_pick
  import xram2_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] last_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  logic [IDW-1:0] candIdx;

  // Walk the requesters starting just past the previous winner and keep the first hit.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    candIdx = '0;
    for (int k = 1; k <= N; k++) begin
      candIdx = IDW'((int'(last_i) + k) % N);
      if (!any_o && req_i[candIdx]) begin
        any_o          = 1'b1;
        gnt_o[candIdx] = 1'b1;
        idx_o          = candIdx;
      end
    end
  end

endmodule

// File: rtl/xram2_arb.sv
// Round-robin arbiter and read-response router for port B of the xram.
// Optional feature: define XRAM2_ARB_FIXED_PRIO_EN to give requester 0 absolute
// priority, with requesters 1..NUM_REQ-1 rotating among themselves.
module xram2_arb
  import xram2_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 1
) (
  input  logic                       clka,
  input  logic                       rstn,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [DATA_W-1:0]          ram_din,
  output logic                       ram_regce,
  output logic                       ram_rst,
  input  logic [DATA_W-1:0]          ram_dout
);

  localparam int              ID_W       = clog2(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_RESET = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]    last_q;
  logic [ID_W-1:0]    last_d;
  logic [NUM_REQ-1:0] pickReq;
  logic [NUM_REQ-1:0] pickGnt;
  logic [ID_W-1:0]    pickIdx;
  logic               pickAny;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    winIdx;
  logic               accept;
  logic               selWe;
  rd_tag_t            tag_d;
  rd_tag_t            tag_q [RD_LAT];

`ifdef XRAM2_ARB_FIXED_PRIO_EN
  assign pickReq = req_valid & ~NUM_REQ'(1);
`else
  assign pickReq = req_valid;
`endif

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_pick (
    .req_i  (pickReq),
    .last_i (last_q),
    .gnt_o  (pickGnt),
    .idx_o  (pickIdx),
    .any_o  (pickAny)
  );

  // Choose this cycle's winner; requester 0 may pre-empt the rotating picker.
  always_comb begin
    gnt    = '0;
    winIdx = '0;
    accept = 1'b0;
    last_d = last_q;
`ifdef XRAM2_ARB_FIXED_PRIO_EN
    if (req_valid[0]) begin
      gnt[0] = 1'b1;
      accept = 1'b1;
    end else if (pickAny) begin
      gnt    = pickGnt;
      winIdx = pickIdx;
      accept = 1'b1;
      last_d = pickIdx;
    end
`else
    if (pickAny) begin
      gnt    = pickGnt;
      winIdx = pickIdx;
      accept = 1'b1;
      last_d = pickIdx;
    end
`endif
  end

  // Steer the winner's fields onto port B; zero when nobody is granted.
  always_comb begin
    selWe    = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        selWe    = req_we[i];
        ram_addr = req_addr[i*ADDR_W +: ADDR_W];
        ram_din  = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign req_ready = gnt;
  assign ram_en    = accept;
  assign ram_we    = selWe;
  assign ram_rst   = RAM_RST_VALUE;
  assign rsp_rdata = ram_dout;

  assign tag_d.valid = accept & ~selWe;
  assign tag_d.id    = TAG_ID_W'(winIdx);

  // Round-robin pointer: remembers the last rotating winner.
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      last_q <= LAST_RESET;
    end else begin
      last_q <= last_d;
    end
  end

  // Read tags ride a shift pipe matching the RAM latency; reset drops them.
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= TAG_RESET;
      end
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Decode the tag leaving the pipe into a one-hot response strobe.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = tag_q[RD_LAT-1].valid && (tag_q[RD_LAT-1].id == TAG_ID_W'(i));
    end
  end

  generate
    if (RD_LAT >= 2) begin : gRegcePipe
      assign ram_regce = tag_q[RD_LAT-2].valid;
    end else begin : gRegceAlive
      logic alive_q;
      // Without an output register the enable just stays on once out of reset.
      always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
          alive_q <= 1'b0;
        end else begin
          alive_q <= 1'b1;
        end
      end
      assign ram_regce = alive_q;
    end
  endgenerate

endmodule
